mem_arbiter: RTL and testbench

- Two-master, one-slave arbiter between the core's memory requesters and the single memory bus.
- Master 0 is instruction fetch (read-only, word-wide); master 1 is the backend load/store unit.
- Sits directly upstream of the fetch stage's memory port: it drives fetch's access-OK, read data and exception inputs.
- Uses round-robin grant, latches request attributes at grant time, and keeps every launched bus transaction running to completion, even if its master withdraws.

---
 rtl/mem_arbiter_pkg.sv | 34 +++
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 95 +++++++++
 tb/tb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and helpers for the two-master memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned EXCEPTION_LEN = 4;
  localparam logic [EXCEPTION_LEN-1:0] EXCEPTION_NONE = '0;

  localparam logic [1:0] MEM_WIDTH_BYTE = 2'd0;
  localparam logic [1:0] MEM_WIDTH_HALF = 2'd1;
  localparam logic [1:0] MEM_WIDTH_WORD = 2'd2;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_GNT_IF = 2'd1;
  localparam logic [1:0] ARB_GNT_LS = 2'd2;

  // Attributes captured at grant time and driven onto the bus.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  width;
    logic        is_read;
  } bus_attr_t;

  // Round-robin choice out of IDLE; prio=1 favours load/store on a tie.
  function automatic logic [1:0] arb_pick(input logic if_req, input logic ls_req,
                                          input logic prio);
    logic [1:0] sel;
    sel = ARB_IDLE;
    if (if_req && ls_req) sel = prio ? ARB_GNT_LS : ARB_GNT_IF;
    else if (if_req)      sel = ARB_GNT_IF;
    else if (ls_req)      sel = ARB_GNT_LS;
    return sel;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and bus-side signals of the memory arbiter.
// slave: the arbiter's view; master: the surrounding core/memory's view.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic [31:0]              ifAddr_In;
  logic                     ifAccess_In;
  logic                     ifAccessOK_Out;
  logic [31:0]              ifData_Out;
  logic [EXCEPTION_LEN-1:0] ifException_Out;

  logic [31:0]              lsAddr_In;
  logic [31:0]              lsData_In;
  logic [1:0]               lsDataWidth_In;
  logic                     lsIsRead_In;
  logic                     lsAccess_In;
  logic                     lsAccessOK_Out;
  logic [31:0]              lsData_Out;
  logic [EXCEPTION_LEN-1:0] lsException_Out;

  logic [31:0]              busAddr_Out;
  logic [31:0]              busData_Out;
  logic [1:0]               busDataWidth_Out;
  logic                     busIsRead_Out;
  logic                     busAccess_Out;
  logic                     busAccessOK_In;
  logic [31:0]              busData_In;
  logic [EXCEPTION_LEN-1:0] busException_In;

  modport slave (
    input  ifAddr_In, ifAccess_In,
    output ifAccessOK_Out, ifData_Out, ifException_Out,
    input  lsAddr_In, lsData_In, lsDataWidth_In, lsIsRead_In, lsAccess_In,
    output lsAccessOK_Out, lsData_Out, lsException_Out,
    output busAddr_Out, busData_Out, busDataWidth_Out, busIsRead_Out, busAccess_Out,
    input  busAccessOK_In, busData_In, busException_In
  );

  modport master (
    output ifAddr_In, ifAccess_In,
    input  ifAccessOK_Out, ifData_Out, ifException_Out,
    output lsAddr_In, lsData_In, lsDataWidth_In, lsIsRead_In, lsAccess_In,
    input  lsAccessOK_Out, lsData_Out, lsException_Out,
    input  busAddr_Out, busData_Out, busDataWidth_Out, busIsRead_Out, busAccess_Out,
    output busAccessOK_In, busData_In, busException_In
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store onto one
// memory bus. Attributes are latched at grant; a launched transaction always
// runs to completion, and a withdrawn master's response is swallowed.
module mem_arbiter #(
  parameter logic INIT_PRIO = 1'b0
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave arb
);
  import mem_arbiter_pkg::*;

  logic [1:0] state, state_nxt;
  logic       prio, prio_nxt;
  logic       abandoned, abandoned_nxt;
  bus_attr_t  attr_q, attr_nxt;
  bus_attr_t  if_attr, ls_attr;
  logic       grant;
  logic       if_ok, ls_ok;

  assign if_attr = '{addr: arb.ifAddr_In, data: '0, width: MEM_WIDTH_WORD, is_read: 1'b1};
  assign ls_attr = '{addr: arb.ifAddr_In & '0 | arb.lsAddr_In, data: arb.lsData_In,
                     width: arb.lsDataWidth_In, is_read: arb.lsIsRead_In};

  // Next state, priority, withdrawal tracking and attribute capture.
  always_comb begin
    state_nxt     = state;
    prio_nxt      = prio;
    abandoned_nxt = abandoned;
    attr_nxt      = attr_q;
    unique case (state)
      ARB_IDLE: state_nxt = arb_pick(arb.ifAccess_In, arb.lsAccess_In, prio);
      ARB_GNT_IF: begin
        if (arb.busAccessOK_In) begin
          prio_nxt      = 1'b1;
          abandoned_nxt = 1'b0;
          if (arb.lsAccess_In)                  state_nxt = ARB_GNT_LS;
          else if (arb.ifAccess_In && abandoned) state_nxt = ARB_GNT_IF;
          else                                   state_nxt = ARB_IDLE;
        end else if (!arb.ifAccess_In) begin
          abandoned_nxt = 1'b1;
        end
      end
      ARB_GNT_LS: begin
        if (arb.busAccessOK_In) begin
          prio_nxt      = 1'b0;
          abandoned_nxt = 1'b0;
          if (arb.ifAccess_In)                   state_nxt = ARB_GNT_IF;
          else if (arb.lsAccess_In && abandoned) state_nxt = ARB_GNT_LS;
          else                                   state_nxt = ARB_IDLE;
        end else if (!arb.lsAccess_In) begin
          abandoned_nxt = 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
    // A fresh grant happens leaving IDLE or on a completion edge; holding a
    // grant without OK keeps the previously latched attributes.
    grant = (state_nxt != ARB_IDLE) && ((state == ARB_IDLE) || arb.busAccessOK_In);
    if (grant) attr_nxt = (state_nxt == ARB_GNT_IF) ? if_attr : ls_attr;
  end

  // Arbiter state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      prio      <= INIT_PRIO;
      abandoned <= 1'b0;
      attr_q    <= '0;
    end else begin
      state     <= state_nxt;
      prio      <= prio_nxt;
      abandoned <= abandoned_nxt;
      attr_q    <= attr_nxt;
    end
  end

  assign if_ok = (state == ARB_GNT_IF) && arb.busAccessOK_In && !abandoned;
  assign ls_ok = (state == ARB_GNT_LS) && arb.busAccessOK_In && !abandoned;

  assign arb.busAccess_Out    = (state != ARB_IDLE) && !arb.busAccessOK_In;
  assign arb.busAddr_Out      = attr_q.addr;
  assign arb.busData_Out      = attr_q.data;
  assign arb.busDataWidth_Out = attr_q.width;
  assign arb.busIsRead_Out    = attr_q.is_read;

  assign arb.ifAccessOK_Out  = if_ok;
  assign arb.ifData_Out      = if_ok ? arb.busData_In : '0;
  assign arb.ifException_Out = if_ok ? arb.busException_In : EXCEPTION_NONE;

  assign arb.lsAccessOK_Out  = ls_ok;
  assign arb.lsData_Out      = ls_ok ? arb.busData_In : '0;
  assign arb.lsException_Out = ls_ok ? arb.busException_In : EXCEPTION_NONE;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-cycle vector table plus a response scoreboard,
// followed by a hand-written asynchronous reset sequence.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if arb_if();

  mem_arbiter #(.INIT_PRIO(1'b0)) dut (.clk(clk), .rst(rst), .arb(arb_if));

  typedef struct {
    logic                     rst_before;
    logic                     ifa;
    logic [31:0]              ifaddr;
    logic                     lsa;
    logic [31:0]              lsaddr;
    logic [31:0]              lsdata;
    logic [1:0]               lsw;
    logic                     lsrd;
    logic                     bok;
    logic [31:0]              bdata;
    logic [EXCEPTION_LEN-1:0] bexc;
    logic                     e_bacc;
    logic [31:0]              e_baddr;
    logic [31:0]              e_bdata;
    logic [1:0]               e_bw;
    logic                     e_brd;
    logic                     e_ifok;
    logic                     e_lsok;
  } vec_t;

  typedef struct {
    logic                     master;
    logic [31:0]              data;
    logic [EXCEPTION_LEN-1:0] exc;
  } resp_t;

  localparam logic [1:0] B = MEM_WIDTH_BYTE;
  localparam logic [1:0] H = MEM_WIDTH_HALF;
  localparam logic [1:0] W = MEM_WIDTH_WORD;
  localparam int NV = 34;

  vec_t  vecs[NV];
  resp_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    arb_if.ifAccess_In     = 1'b0;
    arb_if.ifAddr_In       = '0;
    arb_if.lsAccess_In     = 1'b0;
    arb_if.lsAddr_In       = '0;
    arb_if.lsData_In       = '0;
    arb_if.lsDataWidth_In  = B;
    arb_if.lsIsRead_In     = 1'b0;
    arb_if.busAccessOK_In  = 1'b0;
    arb_if.busData_In      = '0;
    arb_if.busException_In = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Pop an expected response when a master sees OK; otherwise its data
  // and exception outputs must read zero.
  task automatic check_resp();
    resp_t e;
    if (arb_if.ifAccessOK_Out === 1'b1) begin
      if (exp_q.size() == 0) cmp("if_unexpected_ok", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        cmp("if_resp_master", {31'd0, e.master}, 32'd0);
        cmp("if_resp_data", arb_if.ifData_Out, e.data);
        cmp("if_resp_exc", {28'd0, arb_if.ifException_Out}, {28'd0, e.exc});
      end
    end else begin
      cmp("if_data_idle", arb_if.ifData_Out, 32'd0);
      cmp("if_exc_idle", {28'd0, arb_if.ifException_Out}, 32'd0);
    end
    if (arb_if.lsAccessOK_Out === 1'b1) begin
      if (exp_q.size() == 0) cmp("ls_unexpected_ok", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        cmp("ls_resp_master", {31'd0, e.master}, 32'd1);
        cmp("ls_resp_data", arb_if.lsData_Out, e.data);
        cmp("ls_resp_exc", {28'd0, arb_if.lsException_Out}, {28'd0, e.exc});
      end
    end else begin
      cmp("ls_data_idle", arb_if.lsData_Out, 32'd0);
      cmp("ls_exc_idle", {28'd0, arb_if.lsException_Out}, 32'd0);
    end
  endtask

  initial begin
    resp_t r;
    drive_idle();

    // rst, ifa ifaddr, lsa lsaddr lsdata lsw lsrd, bok bdata bexc | bacc baddr bdata bw brd, ifok lsok
    // Fetch-only read
    vecs[0]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h100, 32'h0, W, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b1, 32'h13, 4'h0, 1'b0, 32'h100, 32'h0, W, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h100, 32'h0, W, 1'b1, 1'b0, 1'b0};
    // Simultaneous requests from reset, back-to-back grants, later tie
    vecs[4]  = '{1'b1, 1'b1, 32'h300, 1'b1, 32'h2000, 32'hDEADBEEF, B, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h300, 1'b1, 32'h2000, 32'hDEADBEEF, B, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h300, 32'h0, W, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h300, 1'b1, 32'h2000, 32'hDEADBEEF, B, 1'b0, 1'b1, 32'h11, 4'h0, 1'b0, 32'h300, 32'h0, W, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h304, 1'b1, 32'h2000, 32'hDEADBEEF, B, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h2000, 32'hDEADBEEF, B, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'h304, 1'b1, 32'h2000, 32'hDEADBEEF, B, 1'b0, 1'b1, 32'hA5A5A5A5, 4'h0, 1'b0, 32'h2000, 32'hDEADBEEF, B, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'h304, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h304, 32'h0, W, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h304, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b1, 32'h22, 4'h0, 1'b0, 32'h304, 32'h0, W, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 32'h308, 1'b1, 32'h2004, 32'h12345678, H, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 32'h304, 32'h0, W, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 32'h308, 1'b1, 32'h2004, 32'h12345678, H, 1'b1, 1'b0, 32'h0, 4'h0, 1'b1, 32'h2004, 32'h12345678, H, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 32'h308, 1'b1, 32'h2004, 32'h12345678, H, 1'b1, 1'b1, 32'hCAFE0000, 4'h0, 1'b0, 32'h2004, 32'h12345678, H, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 32'h308, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h308, 32'h0, W, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 32'h308, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b1, 32'h33, 4'h0, 1'b0, 32'h308, 32'h0, W, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h308, 32'h0, W, 1'b1, 1'b0, 1'b0};
    // Fetch withdrawal and re-request
    vecs[17] = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h308, 32'h0, W, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h100, 32'h0, W, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 32'h100, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h100, 32'h0, W, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h100, 32'h0, W, 1'b1, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b1, 32'hBAD, 4'h0, 1'b0, 32'h100, 32'h0, W, 1'b1, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h200, 32'h0, W, 1'b1, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b1, 32'h44, 4'h0, 1'b0, 32'h200, 32'h0, W, 1'b1, 1'b1, 1'b0};
    vecs[24] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h200, 32'h0, W, 1'b1, 1'b0, 1'b0};
    // Load with exception pass-through, then exception held without OK
    vecs[25] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h4000, 32'h0, W, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 32'h200, 32'h0, W, 1'b1, 1'b0, 1'b0};
    vecs[26] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h4000, 32'h0, W, 1'b1, 1'b0, 32'h0, 4'h0, 1'b1, 32'h4000, 32'h0, W, 1'b1, 1'b0, 1'b0};
    vecs[27] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h4000, 32'h0, W, 1'b1, 1'b1, 32'h55, 4'h5, 1'b0, 32'h4000, 32'h0, W, 1'b1, 1'b0, 1'b1};
    vecs[28] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b0, 32'h99, 4'h5, 1'b0, 32'h4000, 32'h0, W, 1'b1, 1'b0, 1'b0};
    // Spurious OK in IDLE, then a normal fetch
    vecs[29] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b1, 32'h77, 4'h3, 1'b0, 32'h4000, 32'h0, W, 1'b1, 1'b0, 1'b0};
    vecs[30] = '{1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h4000, 32'h0, W, 1'b1, 1'b0, 1'b0};
    vecs[31] = '{1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h500, 32'h0, W, 1'b1, 1'b0, 1'b0};
    vecs[32] = '{1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b1, 32'h66, 4'h0, 1'b0, 32'h500, 32'h0, W, 1'b1, 1'b1, 1'b0};
    vecs[33] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, B, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h500, 32'h0, W, 1'b1, 1'b0, 1'b0};

    // Reset state while rst is held
    #2;
    cmp("rst_bus_access", {31'd0, arb_if.busAccess_Out}, 32'd0);
    cmp("rst_bus_addr", arb_if.busAddr_Out, 32'd0);
    cmp("rst_bus_data", arb_if.busData_Out, 32'd0);
    cmp("rst_if_ok", {31'd0, arb_if.ifAccessOK_Out}, 32'd0);
    cmp("rst_ls_ok", {31'd0, arb_if.lsAccessOK_Out}, 32'd0);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst_before) do_reset();
      @(posedge clk);
      #1;
      arb_if.ifAccess_In     = vecs[i].ifa;
      arb_if.ifAddr_In       = vecs[i].ifaddr;
      arb_if.lsAccess_In     = vecs[i].lsa;
      arb_if.lsAddr_In       = vecs[i].lsaddr;
      arb_if.lsData_In       = vecs[i].lsdata;
      arb_if.lsDataWidth_In  = vecs[i].lsw;
      arb_if.lsIsRead_In     = vecs[i].lsrd;
      arb_if.busAccessOK_In  = vecs[i].bok;
      arb_if.busData_In      = vecs[i].bdata;
      arb_if.busException_In = vecs[i].bexc;
      if (vecs[i].e_ifok) begin
        r = '{1'b0, vecs[i].bdata, vecs[i].bexc};
        exp_q.push_back(r);
      end
      if (vecs[i].e_lsok) begin
        r = '{1'b1, vecs[i].bdata, vecs[i].bexc};
        exp_q.push_back(r);
      end
      @(negedge clk);
      cmp($sformatf("v%0d_bus_access", i), {31'd0, arb_if.busAccess_Out}, {31'd0, vecs[i].e_bacc});
      cmp($sformatf("v%0d_bus_addr", i), arb_if.busAddr_Out, vecs[i].e_baddr);
      cmp($sformatf("v%0d_bus_data", i), arb_if.busData_Out, vecs[i].e_bdata);
      cmp($sformatf("v%0d_bus_width", i), {30'd0, arb_if.busDataWidth_Out}, {30'd0, vecs[i].e_bw});
      cmp($sformatf("v%0d_bus_isread", i), {31'd0, arb_if.busIsRead_Out}, {31'd0, vecs[i].e_brd});
      cmp($sformatf("v%0d_if_ok", i), {31'd0, arb_if.ifAccessOK_Out}, {31'd0, vecs[i].e_ifok});
      cmp($sformatf("v%0d_ls_ok", i), {31'd0, arb_if.lsAccessOK_Out}, {31'd0, vecs[i].e_lsok});
      check_resp();
    end

    // Asynchronous reset in GNT_LS; priority currently favours load/store.
    @(posedge clk);
    #1;
    drive_idle();
    arb_if.lsAccess_In    = 1'b1;
    arb_if.lsAddr_In      = 32'h7000;
    arb_if.lsDataWidth_In = W;
    arb_if.lsIsRead_In    = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    cmp("ar_pre_bus_access", {31'd0, arb_if.busAccess_Out}, 32'd1);
    cmp("ar_pre_bus_addr", arb_if.busAddr_Out, 32'h7000);
    #2;
    arb_if.ifAccess_In    = 1'b1;
    arb_if.ifAddr_In      = 32'h600;
    arb_if.busAccessOK_In = 1'b1;
    arb_if.busData_In     = 32'h88;
    rst = 1'b1;
    #1;
    cmp("ar_bus_access", {31'd0, arb_if.busAccess_Out}, 32'd0);
    cmp("ar_bus_addr", arb_if.busAddr_Out, 32'd0);
    cmp("ar_if_ok", {31'd0, arb_if.ifAccessOK_Out}, 32'd0);
    cmp("ar_ls_ok", {31'd0, arb_if.lsAccessOK_Out}, 32'd0);
    cmp("ar_ls_data", arb_if.lsData_Out, 32'd0);
    arb_if.busAccessOK_In = 1'b0;
    arb_if.busData_In     = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    cmp("ar_idle_bus_access", {31'd0, arb_if.busAccess_Out}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    cmp("ar_grant_bus_access", {31'd0, arb_if.busAccess_Out}, 32'd1);
    cmp("ar_grant_bus_addr", arb_if.busAddr_Out, 32'h600);
    cmp("ar_grant_isread", {31'd0, arb_if.busIsRead_Out}, 32'd1);
    @(posedge clk);
    #1;
    arb_if.lsAccess_In    = 1'b0;
    arb_if.busAccessOK_In = 1'b1;
    arb_if.busData_In     = 32'h99;
    r = '{1'b0, 32'h99, 4'h0};
    exp_q.push_back(r);
    @(negedge clk);
    cmp("ar_if_ok_done", {31'd0, arb_if.ifAccessOK_Out}, 32'd1);
    check_resp();
    @(posedge clk);
    #1 drive_idle();

    cmp("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
